// File: rtl/nn_pkg.sv
// Shared network constants: neuron output width, final-layer size and the
// argmax state encoding, so every layer and the argmax agree on widths.
package nn_pkg;

  localparam int NN_DATA_WIDTH  = 16;
  localparam int NN_NUM_INPUTS  = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index width for n elements, never below one bit.
  function automatic int nn_index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_finder.sv
// Sequential argmax over the final-layer neuron outputs: accepts one packed
// vector, scans one element per cycle and reports the winning index and value.
module argmax_finder
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = NN_NUM_INPUTS,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int INDEX_WIDTH = nn_index_width(NUM_INPUTS)
) (
  input  logic                             s_axi_aclk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             i_ready,
  output logic [INDEX_WIDTH-1:0]           o_index,
  output logic [DATA_WIDTH-1:0]            o_max,
  output logic                             o_valid,
  output logic                             o_busy
);

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic [1:0]                      state_r;
  logic [1:0]                      state_next_s;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] buf_r;
  logic [INDEX_WIDTH-1:0]          count_r;
  logic [INDEX_WIDTH-1:0]          run_index_r;
  logic signed [DATA_WIDTH-1:0]    run_max_r;
  logic [INDEX_WIDTH-1:0]          res_index_r;
  logic [DATA_WIDTH-1:0]           res_max_r;
  logic                            valid_r;
  logic                            accept_s;
  logic                            last_s;
  logic signed [DATA_WIDTH-1:0]    cand_s;
  logic signed [DATA_WIDTH-1:0]    best_max_s;
  logic [INDEX_WIDTH-1:0]          best_index_s;

  // Acceptance and the strict signed compare of the current element (ties keep the older index).
  always_comb begin
    accept_s = i_valid && (state_r == ST_IDLE) && !rst;
    cand_s   = buf_r[DATA_WIDTH-1:0];
    last_s   = (count_r == LAST_INDEX);
    if (cand_s > run_max_r) begin
      best_max_s   = cand_s;
      best_index_s = count_r;
    end else begin
      best_max_s   = run_max_r;
      best_index_s = run_index_r;
    end
  end

  // Next-state logic for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = (NUM_INPUTS == 1) ? ST_DONE : ST_SCAN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, buffer and result registers; the buffer shifts so the element
  // under test always sits in the low slot, which keeps the compare mux-free.
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      buf_r       <= '0;
      count_r     <= '0;
      run_index_r <= '0;
      run_max_r   <= '0;
      res_index_r <= '0;
      res_max_r   <= '0;
      valid_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            buf_r       <= i_data >> DATA_WIDTH;
            run_max_r   <= i_data[DATA_WIDTH-1:0];
            run_index_r <= '0;
            count_r     <= (NUM_INPUTS == 1) ? '0 : INDEX_WIDTH'(1);
            if (NUM_INPUTS == 1) begin
              res_max_r   <= i_data[DATA_WIDTH-1:0];
              res_index_r <= '0;
              valid_r     <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          run_max_r   <= best_max_s;
          run_index_r <= best_index_s;
          buf_r       <= buf_r >> DATA_WIDTH;
          if (last_s) begin
            res_max_r   <= best_max_s;
            res_index_r <= best_index_s;
            valid_r     <= 1'b1;
          end else begin
            count_r <= count_r + 1'b1;
          end
        end
        ST_DONE: begin
          count_r <= '0;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet for the whole reset window, including the cycle it is raised.
  assign i_ready = (state_r == ST_IDLE) && !rst;
  assign o_busy  = ((state_r == ST_SCAN) || (state_r == ST_DONE)) && !rst;
  assign o_valid = valid_r && !rst;
  assign o_index = rst ? '0 : res_index_r;
  assign o_max   = rst ? '0 : res_max_r;

endmodule
